// File: rtl/intersection_controller.sv
// Two-road intersection sequencer: main road green by default, side road
// served on vehicle or latched pedestrian demand, with yellow/all-red clearance.
module intersection_controller #(
    parameter int MIN_MAIN_GREEN = 8,
    parameter int SIDE_GREEN     = 6,
    parameter int YELLOW         = 3,
    parameter int ALL_RED        = 1,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_MAIN_GREEN  = 3'd0,
        ST_MAIN_YELLOW = 3'd1,
        ST_ALL_RED_1   = 3'd2,
        ST_SIDE_GREEN  = 3'd3,
        ST_SIDE_YELLOW = 3'd4,
        ST_ALL_RED_2   = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] MG_LAST  = CNT_W'(MIN_MAIN_GREEN - 1);
    localparam logic [CNT_W-1:0] SG_LAST  = CNT_W'(SIDE_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic               ped_pending_q, ped_pending_d;
    logic               walk_q, walk_d;
    logic               enter_side, exit_side;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MAIN_GREEN: begin
                if (timer_q >= MG_LAST && (side_req || ped_pending_q))
                    state_d = ST_MAIN_YELLOW;
            end
            ST_MAIN_YELLOW: begin
                if (timer_q == YEL_LAST)
                    state_d = ST_ALL_RED_1;
            end
            ST_ALL_RED_1: begin
                if (timer_q == AR_LAST)
                    state_d = ST_SIDE_GREEN;
            end
            ST_SIDE_GREEN: begin
                if (timer_q == SG_LAST)
                    state_d = ST_SIDE_YELLOW;
            end
            ST_SIDE_YELLOW: begin
                if (timer_q == YEL_LAST)
                    state_d = ST_ALL_RED_2;
            end
            ST_ALL_RED_2: begin
                if (timer_q == AR_LAST)
                    state_d = ST_MAIN_GREEN;
            end
            default: state_d = ST_ALL_RED_2;
        endcase
    end

    // Timer restarts on every phase change and saturates while main holds
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)
            timer_d = '0;
        else if (!(&timer_q))
            timer_d = timer_q + CNT_W'(1);
    end

    assign enter_side = (state_q == ST_ALL_RED_1) && (state_d == ST_SIDE_GREEN);
    assign exit_side  = (state_q == ST_SIDE_GREEN) && (state_d != ST_SIDE_GREEN);

    // A request arriving on the side-green entry edge counts as served
    always_comb begin
        ped_pending_d = ped_pending_q | ped_req;
        walk_d        = walk_q;
        if (enter_side) begin
            ped_pending_d = 1'b0;
            walk_d        = ped_pending_q;
        end else if (exit_side) begin
            walk_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ALL_RED_2;
            timer_q       <= '0;
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
            walk_q        <= walk_d;
        end
    end

    always_comb begin
        main_red    = 1'b0;
        main_yellow = 1'b0;
        main_green  = 1'b0;
        side_red    = 1'b0;
        side_yellow = 1'b0;
        side_green  = 1'b0;
        case (state_q)
            ST_MAIN_GREEN: begin
                main_green = 1'b1;
                side_red   = 1'b1;
            end
            ST_MAIN_YELLOW: begin
                main_yellow = 1'b1;
                side_red    = 1'b1;
            end
            ST_SIDE_GREEN: begin
                main_red   = 1'b1;
                side_green = 1'b1;
            end
            ST_SIDE_YELLOW: begin
                main_red    = 1'b1;
                side_yellow = 1'b1;
            end
            default: begin
                main_red = 1'b1;
                side_red = 1'b1;
            end
        endcase
    end

    assign walk        = (state_q == ST_SIDE_GREEN) & walk_q;
    assign ped_pending = ped_pending_q;
    assign state       = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: directed scenarios plus random traffic
// checked against a phase/duration reference model.
module tb_intersection_controller;

    localparam int MIN_MG = 8;
    localparam int SG     = 6;
    localparam int YEL    = 3;
    localparam int AR     = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       main_red, main_yellow, main_green;
    logic       side_red, side_yellow, side_green;
    logic       walk, ped_pending;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    intersection_controller #(
        .MIN_MAIN_GREEN(MIN_MG),
        .SIDE_GREEN(SG),
        .YELLOW(YEL),
        .ALL_RED(AR),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .side_req(side_req),
        .ped_req(ped_req),
        .main_red(main_red),
        .main_yellow(main_yellow),
        .main_green(main_green),
        .side_red(side_red),
        .side_yellow(side_yellow),
        .side_green(side_green),
        .walk(walk),
        .ped_pending(ped_pending),
        .state(state)
    );

    always #5 clk = ~clk;

    wire [10:0] got = {state, main_red, main_yellow, main_green,
                       side_red, side_yellow, side_green, walk, ped_pending};

    // Reference model: phase number, cycles spent in phase, request latch
    int m_phase = 5;
    int m_elapsed = 1;
    bit m_pend = 0;
    bit m_wflag = 0;

    function automatic int phase_len(input int ph);
        case (ph)
            1, 4:    return YEL;
            2, 5:    return AR;
            3:       return SG;
            default: return MIN_MG;
        endcase
    endfunction

    function automatic void model_step(input bit s, input bit p, input bit r);
        bit leave;
        int nph;
        if (r) begin
            m_phase = 5; m_elapsed = 1; m_pend = 0; m_wflag = 0;
            return;
        end
        if (m_phase == 0)
            leave = (m_elapsed >= MIN_MG) && (s || m_pend);
        else
            leave = (m_elapsed >= phase_len(m_phase));
        if (leave) begin
            nph = (m_phase + 1) % 6;
            if (nph == 3) begin
                m_wflag = m_pend;
                m_pend  = 0;
            end else begin
                m_pend = m_pend | p;
            end
            if (m_phase == 3) m_wflag = 0;
            m_phase   = nph;
            m_elapsed = 1;
        end else begin
            m_pend = m_pend | p;
            m_elapsed++;
        end
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [5:0] lamps;
        case (m_phase)
            0:       lamps = 6'b001100;
            1:       lamps = 6'b010100;
            3:       lamps = 6'b100001;
            4:       lamps = 6'b100010;
            default: lamps = 6'b100100;
        endcase
        return {3'(m_phase), lamps, (m_phase == 3) && m_wflag, m_pend};
    endfunction

    task automatic cyc(input bit s, input bit p, input bit r);
        side_req = s;
        ped_req  = p;
        reset    = r;
        @(posedge clk);
        model_step(s, p, r);
        #1;
    endtask

    task automatic test_reset();
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        checks++;
        if (got !== exp_vec()) begin
            errors++;
            $display("FAIL reset_vec: got %b exp %b", got, exp_vec());
        end
        checks++;
        if (state !== 3'd5 || !main_red || !side_red) begin
            errors++;
            $display("FAIL reset_state: got st=%0d mr=%b sr=%b exp st=5 mr=1 sr=1",
                     state, main_red, side_red);
        end
    endtask

    task automatic test_idle();
        int walks = 0;
        int mg = 0;
        for (int i = 0; i < 55; i++) begin
            cyc(0, 0, 0);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL idle_vec cyc%0d: got %b exp %b", i, got, exp_vec());
            end
            walks += int'(walk);
            mg += int'(main_green);
        end
        checks++;
        if (mg !== 55 || walks !== 0) begin
            errors++;
            $display("FAIL idle_hold: got green=%0d walk=%0d exp green=55 walk=0", mg, walks);
        end
    endtask

    task automatic test_side_service();
        int mg = 0;
        int sgc = 0;
        bit left = 0;
        cyc(0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            cyc(!left && i >= 3, 0, 0);
            if (m_phase != 0) left = 1;
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL side_vec cyc%0d: got %b exp %b", i, got, exp_vec());
            end
            if (!left) mg += int'(main_green);
            sgc += int'(side_green);
        end
        checks++;
        if (mg !== MIN_MG || sgc !== SG) begin
            errors++;
            $display("FAIL side_len: got mg=%0d sg=%0d exp mg=%0d sg=%0d", mg, sgc, MIN_MG, SG);
        end
    endtask

    task automatic test_side_pulse();
        int mg = 0;
        cyc(0, 0, 1);
        for (int i = 0; i < 25; i++) begin
            cyc(i == 2 || i == 3, 0, 0);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL pulse_vec cyc%0d: got %b exp %b", i, got, exp_vec());
            end
            mg += int'(main_green);
        end
        checks++;
        if (mg !== 25) begin
            errors++;
            $display("FAIL pulse_hold: got green=%0d exp 25", mg);
        end
    endtask

    task automatic test_ped();
        int walks = 0;
        cyc(0, 0, 1);
        for (int i = 0; i < 35; i++) begin
            cyc(0, i == 3, 0);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL ped_vec cyc%0d: got %b exp %b", i, got, exp_vec());
            end
            if (i == 3) begin
                checks++;
                if (ped_pending !== 1'b1) begin
                    errors++;
                    $display("FAIL ped_latch: got %b exp 1", ped_pending);
                end
            end
            walks += int'(walk);
        end
        checks++;
        if (walks !== SG) begin
            errors++;
            $display("FAIL ped_walk: got %0d walk cycles exp %0d", walks, SG);
        end
    endtask

    task automatic test_ped_late();
        int walk1 = 0;
        int walk2 = 0;
        int services = 0;
        bit pulsed = 0;
        bit p;
        cyc(0, 0, 1);
        for (int i = 0; i < 70; i++) begin
            p = (m_phase == 3 && !pulsed && services == 1);
            if (p) pulsed = 1;
            cyc(services == 0 && m_phase == 0, p, 0);
            if (m_phase == 3 && m_elapsed == 1) services++;
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL late_vec cyc%0d: got %b exp %b", i, got, exp_vec());
            end
            if (services == 1) walk1 += int'(walk);
            if (services == 2) walk2 += int'(walk);
        end
        checks++;
        if (walk1 !== 0 || walk2 !== SG) begin
            errors++;
            $display("FAIL late_walk: got w1=%0d w2=%0d exp w1=0 w2=%0d", walk1, walk2, SG);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        cyc(0, 0, 1);
        while (m_phase != 4 && guard < 100) begin
            cyc(1, m_phase == 3, 0);
            guard++;
        end
        checks++;
        if (guard >= 100 || ped_pending !== 1'b1 || state !== 3'd4) begin
            errors++;
            $display("FAIL mid_setup: got st=%0d pend=%b exp st=4 pend=1", state, ped_pending);
        end
        cyc(0, 0, 1);
        checks++;
        if (got !== exp_vec() || ped_pending !== 1'b0 || walk !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b exp %b", got, exp_vec());
        end
        for (int i = 0; i < 30; i++) begin
            cyc(i > 10, 0, 0);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL mid_resume cyc%0d: got %b exp %b", i, got, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit s, p, r;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 9) < 3);
            p = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 299) == 0);
            cyc(s, p, r);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL rand_vec cyc%0d: got %b exp %b", i, got, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_side_service();
        test_side_pulse();
        test_ped();
        test_ped_late();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
